mem_byte_sequencer: RTL and testbench

//  Memory-stage controller that turns one 32-bit RV32I load/store (LB/LH/LW/LBU/LHU/SB/SH/SW)

---
 rtl/mem_byte_sequencer.sv | 164 ++++++++++++++++
 tb/tb_mem_byte_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_byte_sequencer.sv
// rtl/mem_byte_sequencer.sv - RV32I load/store sequenced onto a byte-wide, 1-cycle-latency RAM port
module mem_byte_sequencer #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout
);
    typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, RESP} state_t;
    state_t state, state_nxt;

    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       wdata_q, wdata_d, rbuf_q, rbuf_d, rdata_d, word;
    logic [ADDR_W-1:0] base_q, base_d, mem_addr_d;
    logic [1:0]        cnt_q, cnt_d, cnt_inc, cnt_dec, cnt_last;
    logic              resp_valid_d, resp_err_d, mem_en_d, mem_we_d;
    logic [7:0]        mem_din_d;
    logic              accept, req_bad, unused_addr_hi;

    assign req_ready      = (state == IDLE);
    assign accept         = req_valid && req_ready;
    assign unused_addr_hi = ^req_addr[31:ADDR_W];
    assign cnt_inc        = cnt_q + 2'd1;
    assign cnt_dec        = cnt_q - 2'd1;
    // index of the final byte: 0 for B/BU, 1 for H/HU, 3 for W
    assign cnt_last       = {funct3_q[1], funct3_q[1] | funct3_q[0]};

    always_comb begin
        req_bad = 1'b0;
        case (req_funct3)
            3'b011, 3'b110, 3'b111: req_bad = 1'b1;
            default: ;
        endcase
        if (req_we && req_funct3[2]) req_bad = 1'b1;
        if (req_funct3[1:0] == 2'b01 && req_addr[0]) req_bad = 1'b1;
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) req_bad = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = req_bad ? RESP : (req_we ? WRITE : READ);
            READ:    if (cnt_q == cnt_last) state_nxt = DRAIN;
            DRAIN:   state_nxt = RESP;
            WRITE:   if (cnt_q == cnt_last) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for the registered outputs; the RAM sees each address one edge after it is set.
    always_comb begin
        funct3_d     = funct3_q;
        wdata_d      = wdata_q;
        base_d       = base_q;
        cnt_d        = cnt_q;
        rbuf_d       = rbuf_q;
        rdata_d      = rdata;
        word         = rbuf_q;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr;
        mem_din_d    = mem_din;
        case (state)
            IDLE: if (accept) begin
                funct3_d   = req_funct3;
                wdata_d    = req_wdata;
                base_d     = req_addr[ADDR_W-1:0];
                cnt_d      = 2'd0;
                resp_err_d = req_bad;
                if (req_bad) begin
                    resp_valid_d = 1'b1;
                    rdata_d      = '0;
                end else begin
                    mem_en_d   = 1'b1;
                    mem_we_d   = req_we;
                    mem_addr_d = req_addr[ADDR_W-1:0];
                    mem_din_d  = req_wdata[7:0];
                end
            end
            READ: begin
                if (cnt_q != 2'd0) rbuf_d[{cnt_dec, 3'b000} +: 8] = mem_dout;
                if (cnt_q != cnt_last) begin
                    mem_en_d   = 1'b1;
                    cnt_d      = cnt_inc;
                    mem_addr_d = base_q + ADDR_W'(cnt_inc);
                end
            end
            DRAIN: begin
                word[{cnt_q, 3'b000} +: 8] = mem_dout;
                case (funct3_q)
                    3'b000:  rdata_d = {{24{word[7]}}, word[7:0]};
                    3'b001:  rdata_d = {{16{word[15]}}, word[15:0]};
                    3'b100:  rdata_d = {24'h0, word[7:0]};
                    3'b101:  rdata_d = {16'h0, word[15:0]};
                    default: rdata_d = word;
                endcase
                resp_valid_d = 1'b1;
            end
            WRITE: begin
                if (cnt_q == cnt_last) begin
                    resp_valid_d = 1'b1;
                end else begin
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b1;
                    cnt_d      = cnt_inc;
                    mem_addr_d = base_q + ADDR_W'(cnt_inc);
                    mem_din_d  = wdata_q[{cnt_inc, 3'b000} +: 8];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_q   <= '0;
            wdata_q    <= '0;
            base_q     <= '0;
            cnt_q      <= '0;
            rbuf_q     <= '0;
            rdata      <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
        end else begin
            funct3_q   <= funct3_d;
            wdata_q    <= wdata_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            rbuf_q     <= rbuf_d;
            rdata      <= rdata_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            mem_en     <= mem_en_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_din    <= mem_din_d;
        end
    end
endmodule

// File: tb/tb_mem_byte_sequencer.sv
// tb/tb_mem_byte_sequencer.sv - self-checking bench for mem_byte_sequencer against an 8-byte RAM model
module tb_mem_byte_sequencer;
    localparam int ADDR_W = 13;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]        req_funct3 = 3'b0;
    logic [31:0]       req_addr = 32'h0, req_wdata = 32'h0;
    logic              req_ready, resp_valid, resp_err, mem_en, mem_we;
    logic [31:0]       rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din, mem_dout;
    logic              ram_clear = 1'b0;

    always #5 clk = ~clk;

    mem_byte_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    typedef struct packed { logic we; logic [ADDR_W-1:0] addr; logic [7:0] din; } acc_t;
    acc_t       log_q[$];
    logic [7:0] ram [8];
    logic [7:0] ref_mem [8];

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 8; i++) ram[i] <= 8'h00;
        end else if (mem_en) begin
            log_q.push_back(acc_t'{mem_we, mem_addr, mem_din});
            if (mem_we) ram[mem_addr[2:0]] <= mem_din;
            else        mem_dout <= ram[mem_addr[2:0]];
        end
    end

    int          n_chk = 0, n_pass = 0;
    logic [31:0] exp_rdata = 32'h0;

    function automatic int nbytes(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic is_bad(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        if (we && f3 >= 3'd4) return 1'b1;
        if (nbytes(f3) == 2 && addr % 2 != 0) return 1'b1;
        if (nbytes(f3) == 4 && addr % 4 != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] addr);
        longint v = 0;
        int n = nbytes(f3);
        int a = int'(addr % 8);
        for (int i = 0; i < n; i++) v += longint'(ref_mem[(a + i) % 8]) << (8 * i);
        if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic noise,
                          output int lat, output logic err, output logic [31:0] rd,
                          output int pulse, output int first);
        int w = 0;
        @(negedge clk);
        while (!req_ready && w < 10) begin @(negedge clk); w++; end
        first = log_q.size();
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        if (noise) begin
            req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = $urandom;
        end else begin
            req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
            req_addr = $urandom; req_wdata = $urandom;
        end
        lat = 0;
        @(negedge clk);
        while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
        req_valid = 1'b0;
        err = resp_err;
        rd = rdata;
        pulse = 0;
        while (resp_valid && pulse < 5) begin pulse++; @(negedge clk); end
    endtask

    task automatic test_reset;
        ram_clear = 1'b1;
        for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({resp_valid, resp_err, rdata, mem_en, mem_we, mem_addr, mem_din, req_ready} !==
            {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 13'h0, 8'h00, 1'b1})
            $display("FAIL reset_state: got rv=%b re=%b rd=%h en=%b we=%b a=%h d=%h rdy=%b want all 0, rdy=1",
                     resp_valid, resp_err, rdata, mem_en, mem_we, mem_addr, mem_din, req_ready);
        else n_pass++;
        rst_n = 1'b1;
        ram_clear = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({req_ready, resp_valid, mem_en} !== 3'b100)
            $display("FAIL reset_release: got rdy/rv/en=%b want 100", {req_ready, resp_valid, mem_en});
        else n_pass++;
        exp_rdata = 32'h0;
    endtask

    typedef struct packed {
        logic we; logic [2:0] f3; logic [31:0] addr; logic [31:0] wd; logic [31:0] rd; int lat; logic err;
    } dop_t;
    dop_t dir_tab [15];

    task automatic test_directed;
        int lat, pulse, first, cnt, n;
        logic err;
        logic [31:0] rd;
        logic [ADDR_W-1:0] ea;
        acc_t a;
        dir_tab = '{
            '{1'b1, 3'd2, 32'd0, 32'hDEADBEEF, 32'h00000000, 4, 1'b0},
            '{1'b0, 3'd2, 32'd0, 32'h0,        32'hDEADBEEF, 5, 1'b0},
            '{1'b0, 3'd0, 32'd3, 32'h0,        32'hFFFFFFDE, 2, 1'b0},
            '{1'b0, 3'd4, 32'd3, 32'h0,        32'h000000DE, 2, 1'b0},
            '{1'b1, 3'd1, 32'd6, 32'h12348001, 32'h000000DE, 2, 1'b0},
            '{1'b0, 3'd1, 32'd6, 32'h0,        32'hFFFF8001, 3, 1'b0},
            '{1'b0, 3'd5, 32'd6, 32'h0,        32'h00008001, 3, 1'b0},
            '{1'b0, 3'd2, 32'd2, 32'h0,        32'h00000000, 0, 1'b1},
            '{1'b0, 3'd5, 32'd6, 32'h0,        32'h00008001, 3, 1'b0},
            '{1'b1, 3'd1, 32'd5, 32'h0,        32'h00000000, 0, 1'b1},
            '{1'b0, 3'd2, 32'd4, 32'h0,        32'h80010000, 5, 1'b0},
            '{1'b0, 3'd3, 32'd0, 32'h0,        32'h00000000, 0, 1'b1},
            '{1'b1, 3'd4, 32'd1, 32'h0,        32'h00000000, 0, 1'b1},
            '{1'b1, 3'd0, 32'd7, 32'h000000A5, 32'h00000000, 1, 1'b0},
            '{1'b0, 3'd0, 32'd7, 32'h0,        32'hFFFFFFA5, 2, 1'b0}
        };
        for (int k = 0; k < 15; k++) begin
            run_op(dir_tab[k].we, dir_tab[k].f3, dir_tab[k].addr, dir_tab[k].wd, 1'b0, lat, err, rd, pulse, first);
            n = nbytes(dir_tab[k].f3);
            n_chk++;
            if ({rd, err} !== {dir_tab[k].rd, dir_tab[k].err})
                $display("FAIL dir%0d rdata/err: got %h/%b want %h/%b", k, rd, err, dir_tab[k].rd, dir_tab[k].err);
            else n_pass++;
            n_chk++;
            if (lat !== dir_tab[k].lat || pulse !== 1)
                $display("FAIL dir%0d latency/pulse: got %0d/%0d want %0d/1", k, lat, pulse, dir_tab[k].lat);
            else n_pass++;
            cnt = log_q.size() - first;
            n_chk++;
            if (cnt !== (dir_tab[k].err ? 0 : n))
                $display("FAIL dir%0d access_count: got %0d want %0d", k, cnt, dir_tab[k].err ? 0 : n);
            else n_pass++;
            for (int i = 0; i < cnt && i < n && !dir_tab[k].err; i++) begin
                a = log_q[first + i];
                ea = dir_tab[k].addr[ADDR_W-1:0] + ADDR_W'(i);
                n_chk++;
                if (a.we !== dir_tab[k].we || a.addr !== ea || (a.we && a.din !== 8'(dir_tab[k].wd >> (8 * i))))
                    $display("FAIL dir%0d access%0d: got we=%b a=%h d=%h want we=%b a=%h d=%h", k, i, a.we, a.addr,
                             a.din, dir_tab[k].we, ea, 8'(dir_tab[k].wd >> (8 * i)));
                else n_pass++;
            end
            if (dir_tab[k].we && !dir_tab[k].err)
                for (int i = 0; i < n; i++) ref_mem[(dir_tab[k].addr + i) % 8] = 8'(dir_tab[k].wd >> (8 * i));
            exp_rdata = dir_tab[k].rd;
        end
    endtask

    task automatic test_random;
        int lat, pulse, first, cnt, n, r, exp_lat;
        logic err, we, e_err, noise;
        logic [2:0] f3;
        logic [31:0] rd, addr, wd;
        logic [ADDR_W-1:0] ea;
        acc_t a;
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    f3 = 3'd0;
                2, 3:    f3 = 3'd1;
                4, 5:    f3 = 3'd2;
                6:       f3 = 3'd4;
                7:       f3 = 3'd5;
                default: f3 = 3'($urandom_range(3, 7));
            endcase
            we = 1'($urandom);
            addr = $urandom;
            wd = $urandom;
            noise = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'(nbytes(f3) - 1);
            n = nbytes(f3);
            e_err = is_bad(we, f3, addr);
            exp_lat = e_err ? 0 : (we ? n : n + 1);
            if (e_err) exp_rdata = 32'h0;
            else if (!we) exp_rdata = load_val(f3, addr);
            run_op(we, f3, addr, wd, noise, lat, err, rd, pulse, first);
            n_chk++;
            if ({rd, err} !== {exp_rdata, e_err})
                $display("FAIL rnd%0d rdata/err (we=%b f3=%0d a=%h): got %h/%b want %h/%b", k, we, f3, addr,
                         rd, err, exp_rdata, e_err);
            else n_pass++;
            n_chk++;
            if (lat !== exp_lat || pulse !== 1)
                $display("FAIL rnd%0d latency/pulse: got %0d/%0d want %0d/1", k, lat, pulse, exp_lat);
            else n_pass++;
            cnt = log_q.size() - first;
            n_chk++;
            if (cnt !== (e_err ? 0 : n))
                $display("FAIL rnd%0d access_count: got %0d want %0d", k, cnt, e_err ? 0 : n);
            else n_pass++;
            for (int i = 0; i < cnt && i < n && !e_err; i++) begin
                a = log_q[first + i];
                ea = addr[ADDR_W-1:0] + ADDR_W'(i);
                n_chk++;
                if (a.we !== we || a.addr !== ea || (we && a.din !== 8'(wd >> (8 * i))))
                    $display("FAIL rnd%0d access%0d: got we=%b a=%h d=%h want we=%b a=%h d=%h", k, i, a.we,
                             a.addr, a.din, we, ea, 8'(wd >> (8 * i)));
                else n_pass++;
            end
            if (we && !e_err)
                for (int i = 0; i < n; i++) ref_mem[(addr + i) % 8] = 8'(wd >> (8 * i));
        end
    endtask

    task automatic test_reset_mid;
        int lat, pulse, first, stray = 0;
        logic err;
        logic [31:0] rd;
        @(negedge clk);
        while (!req_ready && stray < 10) begin @(negedge clk); stray++; end
        stray = 0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 13'd1})
            $display("FAIL abort_pre: got en/we/a=%b/%b/%h want 1/0/0001", mem_en, mem_we, mem_addr);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({mem_en, mem_we} !== 2'b00) $display("FAIL abort_async: got en/we=%b want 00", {mem_en, mem_we});
        else n_pass++;
        repeat (3) begin @(negedge clk); if (resp_valid !== 1'b0) stray++; end
        rst_n = 1'b1;
        repeat (4) begin @(negedge clk); if (resp_valid !== 1'b0) stray++; end
        n_chk++;
        if (stray !== 0 || req_ready !== 1'b1 || rdata !== 32'h0)
            $display("FAIL abort_after: got stray=%0d rdy=%b rd=%h want 0/1/00000000", stray, req_ready, rdata);
        else n_pass++;
        run_op(1'b0, 3'b010, 32'h0, 32'h0, 1'b0, lat, err, rd, pulse, first);
        n_chk++;
        if ({rd, err} !== {load_val(3'b010, 32'h0), 1'b0} || lat !== 5)
            $display("FAIL abort_next_lw: got %h/%b lat %0d want %h/0 lat 5", rd, err, lat, load_val(3'b010, 32'h0));
        else n_pass++;
        exp_rdata = rd;
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end
endmodule
